// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between register-read results (1 byte) and ALU
// results (2 bytes, LSB first) with one buffer per source and round-robin grants.
module uart_tx_arbiter #(
   parameter int RD_DATA_WIDTH = 8,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int BUSY_TIMEOUT  = 15
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic [RD_DATA_WIDTH-1:0] Rd_data,
   input  logic                     Rd_data_valid,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     ALU_OUT_valid,
   input  logic                     BUSY,
   output logic [RD_DATA_WIDTH-1:0] TX_P_DATA,
   output logic                     TX_D_VLD,
   output logic                     rd_ovf,
   output logic                     alu_ovf,
   output logic                     arb_idle
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND    = 2'd1;
   localparam logic [1:0] WAIT_HI = 2'd2;
   localparam logic [1:0] WAIT_LO = 2'd3;

   localparam logic GNT_RD  = 1'b0;
   localparam logic GNT_ALU = 1'b1;

   if (ALU_OUT_WIDTH != 2 * RD_DATA_WIDTH) begin : g_width_check
      $error("ALU_OUT_WIDTH must be twice RD_DATA_WIDTH");
   end

   logic [1:0]               state;
   logic [1:0]               state_nxt;
   logic                     grant;
   logic                     last_grant;
   logic                     byte_idx;
   logic [CNT_W-1:0]         to_cnt;
   logic [CNT_W-1:0]         to_cnt_inc;
   logic [RD_DATA_WIDTH-1:0] rd_buf;
   logic [ALU_OUT_WIDTH-1:0] alu_buf;
   logic                     rd_pend;
   logic                     alu_pend;
   logic                     pick_alu;
   logic                     byte_done;
   logic                     rd_free;
   logic                     alu_free;

   // With both sources pending, the one not served last wins.
   assign pick_alu   = alu_pend && (!rd_pend || (last_grant == GNT_RD));
   assign to_cnt_inc = to_cnt + CNT_W'(1);

   // A buffer is released during the strobe cycle of its final byte.
   assign rd_free  = (state == SEND) && (grant == GNT_RD);
   assign alu_free = (state == SEND) && (grant == GNT_ALU) && byte_idx;

   assign arb_idle = (state == IDLE) && !rd_pend && !alu_pend;

   always_comb begin
      state_nxt = state;
      byte_done = 1'b0;
      case (state)
         IDLE: begin
            if ((rd_pend || alu_pend) && !BUSY) state_nxt = SEND;
         end
         SEND: begin
            state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (BUSY)                           state_nxt = WAIT_LO;
            else if (to_cnt_inc == TIMEOUT_CNT) byte_done = 1'b1;
         end
         WAIT_LO: begin
            if (!BUSY) byte_done = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // The ALU high byte follows its low byte directly, never interleaved.
      if (byte_done) state_nxt = ((grant == GNT_ALU) && !byte_idx) ? SEND : IDLE;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= GNT_RD;
         last_grant <= GNT_ALU;
         byte_idx   <= 1'b0;
         to_cnt     <= '0;
         rd_buf     <= '0;
         alu_buf    <= '0;
         rd_pend    <= 1'b0;
         alu_pend   <= 1'b0;
         rd_ovf     <= 1'b0;
         alu_ovf    <= 1'b0;
         TX_P_DATA  <= '0;
         TX_D_VLD   <= 1'b0;
      end else begin
         state    <= state_nxt;
         TX_D_VLD <= 1'b0;

         if ((state == IDLE) && (state_nxt == SEND)) begin
            grant      <= pick_alu;
            last_grant <= pick_alu;
            byte_idx   <= 1'b0;
            TX_D_VLD   <= 1'b1;
            TX_P_DATA  <= pick_alu ? alu_buf[RD_DATA_WIDTH-1:0] : rd_buf;
         end else if (state_nxt == SEND) begin
            byte_idx  <= 1'b1;
            TX_D_VLD  <= 1'b1;
            TX_P_DATA <= alu_buf[ALU_OUT_WIDTH-1:RD_DATA_WIDTH];
         end

         if (state == SEND)         to_cnt <= '0;
         else if (state == WAIT_HI) to_cnt <= to_cnt_inc;

         if (Rd_data_valid) begin
            if (!rd_pend || rd_free) begin
               rd_buf  <= Rd_data;
               rd_pend <= 1'b1;
            end else begin
               rd_ovf <= 1'b1;
            end
         end else if (rd_free) begin
            rd_pend <= 1'b0;
         end

         if (ALU_OUT_valid) begin
            if (!alu_pend || alu_free) begin
               alu_buf  <= ALU_OUT;
               alu_pend <= 1'b1;
            end else begin
               alu_ovf <= 1'b1;
            end
         end else if (alu_free) begin
            alu_pend <= 1'b0;
         end
      end
   end

endmodule
